// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 (double dabble) binary-to-BCD converter.
// Converts one input bit per clock behind a start/busy/done handshake.
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [BIN_W-1:0]   binReg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adjusted;
  logic [BCD_W-1:0]   nextScratch;
  logic               ovfFlag;
  logic               carryOut;
  logic [CNT_W-1:0]   count;

  // Add-3 correction per digit, then the one-bit left shift of {scratch, binReg}.
  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    nextScratch = {adjusted[BCD_W-2:0], binReg[BIN_W-1]};
    carryOut    = adjusted[BCD_W-1];
  end

  // The bit shifted out of the top digit is lost, so it is folded into the overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      binReg   <= '0;
      scratch  <= '0;
      ovfFlag  <= 1'b0;
      count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            binReg  <= bin_in;
            scratch <= '0;
            ovfFlag <= 1'b0;
            count   <= CNT_W'(BIN_W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= nextScratch;
          binReg  <= binReg << 1;
          ovfFlag <= ovfFlag | carryOut;
          count   <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            bcd_out  <= nextScratch;
            overflow <= ovfFlag | carryOut;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: four parameterisations checked every cycle against an
// arithmetic reference model, plus hand-computed literal results.
module tb_bin2bcd_seq;

  localparam int N = 4;
  localparam int W [N] = '{8, 16, 8, 1};
  localparam int D [N] = '{3, 5, 2, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        startV [N];
  logic [15:0] binV   [N];
  logic        dBusy  [N];
  logic        dDone  [N];
  logic        dOvf   [N];
  logic [19:0] dBcd   [N];
  logic [11:0] bcd0;
  logic [19:0] bcd1;
  logic [7:0]  bcd2;
  logic [3:0]  bcd3;

  logic        mBusy [N];
  logic        mDone [N];
  logic        mOvf  [N];
  logic [19:0] mBcd  [N];
  int          mCnt  [N];
  longint      mVal  [N];

  int  vectors = 0;
  int  errors  = 0;
  bit  checkEn = 1'b0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u0 (
    .clk(clk), .rst(rst), .start(startV[0]), .bin_in(binV[0][7:0]),
    .busy(dBusy[0]), .done(dDone[0]), .bcd_out(bcd0), .overflow(dOvf[0]));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u1 (
    .clk(clk), .rst(rst), .start(startV[1]), .bin_in(binV[1]),
    .busy(dBusy[1]), .done(dDone[1]), .bcd_out(bcd1), .overflow(dOvf[1]));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u2 (
    .clk(clk), .rst(rst), .start(startV[2]), .bin_in(binV[2][7:0]),
    .busy(dBusy[2]), .done(dDone[2]), .bcd_out(bcd2), .overflow(dOvf[2]));
  bin2bcd_seq #(.BIN_W(1), .DIGITS(1)) u3 (
    .clk(clk), .rst(rst), .start(startV[3]), .bin_in(binV[3][0:0]),
    .busy(dBusy[3]), .done(dDone[3]), .bcd_out(bcd3), .overflow(dOvf[3]));

  assign dBcd[0] = 20'(bcd0);
  assign dBcd[1] = bcd1;
  assign dBcd[2] = 20'(bcd2);
  assign dBcd[3] = 20'(bcd3);

  function automatic longint pow10(input int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] toBcd(input longint v, input int d);
    logic [19:0] r = '0;
    longint      x = v % pow10(d);
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: accepted operand produces its decimal result W cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mBusy[i] <= 1'b0;
        mDone[i] <= 1'b0;
        mOvf[i]  <= 1'b0;
        mBcd[i]  <= '0;
        mCnt[i]  <= 0;
        mVal[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        mDone[i] <= 1'b0;
        if (!mBusy[i]) begin
          if (startV[i]) begin
            mBusy[i] <= 1'b1;
            mCnt[i]  <= W[i];
            mVal[i]  <= longint'(binV[i]) % (longint'(1) << W[i]);
          end
        end else begin
          mCnt[i] <= mCnt[i] - 1;
          if (mCnt[i] == 1) begin
            mBusy[i] <= 1'b0;
            mDone[i] <= 1'b1;
            mBcd[i]  <= toBcd(mVal[i], D[i]);
            mOvf[i]  <= (mVal[i] >= pow10(D[i]));
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [19:0] act, input logic [19:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < N; i++) begin
        checkOutput($sformatf("u%0d.busy", i), 20'(dBusy[i]), 20'(mBusy[i]));
        checkOutput($sformatf("u%0d.done", i), 20'(dDone[i]), 20'(mDone[i]));
        checkOutput($sformatf("u%0d.bcd", i), dBcd[i], mBcd[i]);
        checkOutput($sformatf("u%0d.ovf", i), 20'(dOvf[i]), 20'(mOvf[i]));
      end
    end
  end

  task automatic applyNow(input int i, input logic [15:0] value);
    binV[i]   = value;
    startV[i] = 1'b1;
    @(posedge clk);
    #1 startV[i] = 1'b0;
  endtask

  task automatic applyStimulus(input int i, input logic [15:0] value);
    @(posedge clk);
    #1 applyNow(i, value);
  endtask

  task automatic waitDone(input int i, input logic [19:0] expBcd, input logic expOvf, input string name);
    bit found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (dDone[i] === 1'b1) found = 1'b1;
    end
    if (found) begin
      checkOutput({name, ".bcd"}, dBcd[i], expBcd);
      checkOutput({name, ".ovf"}, 20'(dOvf[i]), 20'(expOvf));
    end else begin
      vectors++;
      errors++;
      $display("[TB] FAIL %s.timeout: got no done, expected done within 40 cycles", name);
    end
  endtask

  initial begin
    int doneCount;
    for (int i = 0; i < N; i++) begin
      startV[i] = 1'b0;
      binV[i]   = '0;
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.busy", 20'(dBusy[0]), 20'd0);
    checkOutput("rst.done", 20'(dDone[1]), 20'd0);
    checkOutput("rst.bcd", dBcd[1], 20'd0);
    checkOutput("rst.ovf", 20'(dOvf[2]), 20'd0);
    rst = 1'b0;
    checkEn = 1'b1;

    applyStimulus(0, 16'd255);
    checkOutput("busyAfterAccept", 20'(dBusy[0]), 20'd1);
    waitDone(0, 20'h00255, 1'b0, "u0.255");
    applyStimulus(0, 16'd0);
    waitDone(0, 20'h00000, 1'b0, "u0.0");
    applyStimulus(0, 16'd100);
    waitDone(0, 20'h00100, 1'b0, "u0.100");

    applyStimulus(1, 16'd65535);
    waitDone(1, 20'h65535, 1'b0, "u1.65535");
    applyNow(1, 16'd40960);
    waitDone(1, 20'h40960, 1'b0, "u1.40960");

    applyStimulus(2, 16'd200);
    waitDone(2, 20'h00000, 1'b1, "u2.200");
    applyStimulus(2, 16'd99);
    waitDone(2, 20'h00099, 1'b0, "u2.99");

    applyStimulus(0, 16'd37);
    repeat (3) @(posedge clk);
    #1 applyNow(0, 16'd200);
    waitDone(0, 20'h00037, 1'b0, "u0.ignoreStart");
    doneCount = 0;
    repeat (10) begin
      @(negedge clk);
      if (dDone[0] === 1'b1) doneCount++;
    end
    checkOutput("singleDone", 20'(doneCount), 20'd0);

    applyStimulus(3, 16'd1);
    waitDone(3, 20'h00001, 1'b0, "u3.1");
    applyStimulus(3, 16'd0);
    waitDone(3, 20'h00000, 1'b0, "u3.0");

    applyStimulus(0, 16'd123);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midRst.busy", 20'(dBusy[0]), 20'd0);
    checkOutput("midRst.done", 20'(dDone[0]), 20'd0);
    checkOutput("midRst.bcd", dBcd[0], 20'd0);
    checkOutput("midRst.ovf", 20'(dOvf[0]), 20'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    doneCount = 0;
    repeat (12) begin
      @(negedge clk);
      if (dDone[0] === 1'b1) doneCount++;
    end
    checkOutput("noDoneAfterRst", 20'(doneCount), 20'd0);
    applyStimulus(0, 16'd77);
    waitDone(0, 20'h00077, 1'b0, "u0.afterRst");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
